// File: rtl/control_unit.sv
// control_unit: hardwired microsequencer for a simple load/store CPU.
// A registered state register (RESET, T0..T7, HALT) and a latched opcode
// drive a purely combinational Moore decode of every control line. The one
// exception is br T6: its PC load is additionally gated by con_ff.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    output logic        run,
    output logic [8:0]  bus_src,
    output logic [9:0]  reg_en,
    output logic [2:0]  gsel,
    output logic        read,
    output logic        write,
    output logic        con_in,
    output logic        inc_pc,
    output logic [4:0]  alu_control
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    // Opcodes
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    // Bus driver bit positions
    localparam int BUS_POUT   = 0;
    localparam int BUS_MDROUT = 1;
    localparam int BUS_COUT   = 2;
    localparam int BUS_BAOUT  = 3;
    localparam int BUS_ROUT   = 4;
    localparam int BUS_HIOUT  = 5;
    localparam int BUS_LOOUT  = 6;
    localparam int BUS_ZLOOUT = 7;
    localparam int BUS_ZHIOUT = 8;

    // Register load-enable bit positions
    localparam int EN_P   = 0;
    localparam int EN_MAR = 1;
    localparam int EN_MDR = 2;
    localparam int EN_IR  = 3;
    localparam int EN_Y   = 4;
    localparam int EN_ZLO = 5;
    localparam int EN_ZHI = 6;
    localparam int EN_HI  = 7;
    localparam int EN_LO  = 8;
    localparam int EN_RIN = 9;

    // Register-field select bit positions
    localparam int G_RA = 0;
    localparam int G_RB = 1;
    localparam int G_RC = 2;

    state_t     state;
    logic [4:0] opcode;

    // Last execute step of each instruction; undefined opcodes stop at T3.
    function automatic state_t final_step(input logic [4:0] op);
        case (op)
            OP_LD, OP_ST:                                   final_step = S_T7;
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: final_step = S_T5;
            OP_MUL, OP_BR:                                  final_step = S_T6;
            default:                                        final_step = S_T3;
        endcase
    endfunction

    // Successor of an execute step that is not the instruction's last.
    function automatic state_t succ(input state_t s);
        case (s)
            S_T3:    succ = S_T4;
            S_T4:    succ = S_T5;
            S_T5:    succ = S_T6;
            S_T6:    succ = S_T7;
            default: succ = S_T0;
        endcase
    endfunction

    // Step sequencing and opcode capture; clr overrides everything, including stop.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (clr) begin
            state  <= S_RESET;
            opcode <= 5'b00000;
        end else begin
            case (state)
                S_RESET: state <= S_T0;
                S_T0:    state <= S_T1;
                S_T1:    state <= S_T2;
                S_T2: begin
                    state  <= S_T3;
                    opcode <= ir[31:27];
                end
                S_HALT:  state <= S_HALT;
                default: begin
                    if (state == S_T3 && opcode == OP_HALT) begin
                        state <= S_HALT;
                    end else if (state == final_step(opcode)) begin
                        state <= stop ? S_HALT : S_T0;
                    end else begin
                        state <= succ(state);
                    end
                end
            endcase
        end
    end

    // Control decode from the current step and latched opcode.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        run         = 1'b0;
        bus_src     = '0;
        reg_en      = '0;
        gsel        = '0;
        read        = 1'b0;
        write       = 1'b0;
        con_in      = 1'b0;
        inc_pc      = 1'b0;
        alu_control = '0;

        case (state)
            S_RESET, S_HALT: ;
            S_T0: begin
                run              = 1'b1;
                bus_src[BUS_POUT] = 1'b1;
                reg_en[EN_MAR]   = 1'b1;
                inc_pc           = 1'b1;
            end
            S_T1: begin
                run            = 1'b1;
                read           = 1'b1;
                reg_en[EN_MDR] = 1'b1;
            end
            S_T2: begin
                run                 = 1'b1;
                bus_src[BUS_MDROUT] = 1'b1;
                reg_en[EN_IR]       = 1'b1;
            end
            default: begin
                run = 1'b1;
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin
                        case (state)
                            S_T3: begin
                                gsel[G_RB]         = 1'b1;
                                bus_src[BUS_BAOUT] = 1'b1;
                                reg_en[EN_Y]       = 1'b1;
                            end
                            S_T4: begin
                                bus_src[BUS_COUT] = 1'b1;
                                reg_en[EN_ZLO]    = 1'b1;
                                alu_control       = ALU_ADD;
                            end
                            S_T5: begin
                                bus_src[BUS_ZLOOUT] = 1'b1;
                                if (opcode == OP_LDI) begin
                                    gsel[G_RA]     = 1'b1;
                                    reg_en[EN_RIN] = 1'b1;
                                end else begin
                                    reg_en[EN_MAR] = 1'b1;
                                end
                            end
                            S_T6: begin
                                reg_en[EN_MDR] = 1'b1;
                                if (opcode == OP_ST) begin
                                    gsel[G_RA]        = 1'b1;
                                    bus_src[BUS_ROUT] = 1'b1;
                                end else begin
                                    read = 1'b1;
                                end
                            end
                            S_T7: begin
                                if (opcode == OP_ST) begin
                                    write = 1'b1;
                                end else begin
                                    bus_src[BUS_MDROUT] = 1'b1;
                                    gsel[G_RA]          = 1'b1;
                                    reg_en[EN_RIN]      = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        case (state)
                            S_T3: begin
                                gsel[G_RB]        = 1'b1;
                                bus_src[BUS_ROUT] = 1'b1;
                                reg_en[EN_Y]      = 1'b1;
                            end
                            S_T4: begin
                                reg_en[EN_ZLO] = 1'b1;
                                if (opcode == OP_ADDI) begin
                                    bus_src[BUS_COUT] = 1'b1;
                                    alu_control       = ALU_ADD;
                                end else begin
                                    gsel[G_RC]        = 1'b1;
                                    bus_src[BUS_ROUT] = 1'b1;
                                    alu_control       = opcode;
                                end
                            end
                            S_T5: begin
                                bus_src[BUS_ZLOOUT] = 1'b1;
                                gsel[G_RA]          = 1'b1;
                                reg_en[EN_RIN]      = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_MUL: begin
                        case (state)
                            S_T3: begin
                                gsel[G_RA]        = 1'b1;
                                bus_src[BUS_ROUT] = 1'b1;
                                reg_en[EN_Y]      = 1'b1;
                            end
                            S_T4: begin
                                gsel[G_RB]        = 1'b1;
                                bus_src[BUS_ROUT] = 1'b1;
                                reg_en[EN_ZLO]    = 1'b1;
                                reg_en[EN_ZHI]    = 1'b1;
                                alu_control       = OP_MUL;
                            end
                            S_T5: begin
                                bus_src[BUS_ZLOOUT] = 1'b1;
                                reg_en[EN_LO]       = 1'b1;
                            end
                            S_T6: begin
                                bus_src[BUS_ZHIOUT] = 1'b1;
                                reg_en[EN_HI]       = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_BR: begin
                        case (state)
                            S_T3: begin
                                gsel[G_RA]        = 1'b1;
                                bus_src[BUS_ROUT] = 1'b1;
                                con_in            = 1'b1;
                            end
                            S_T4: begin
                                bus_src[BUS_POUT] = 1'b1;
                                reg_en[EN_Y]      = 1'b1;
                            end
                            S_T5: begin
                                bus_src[BUS_COUT] = 1'b1;
                                reg_en[EN_ZLO]    = 1'b1;
                                alu_control       = ALU_ADD;
                            end
                            S_T6: begin
                                // Branch taken only when the condition flop is set now.
                                if (con_ff) begin
                                    bus_src[BUS_ZLOOUT] = 1'b1;
                                    reg_en[EN_P]        = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    OP_JR: begin
                        if (state == S_T3) begin
                            gsel[G_RA]        = 1'b1;
                            bus_src[BUS_ROUT] = 1'b1;
                            reg_en[EN_P]      = 1'b1;
                        end
                    end
                    OP_MFHI: begin
                        if (state == S_T3) begin
                            gsel[G_RA]         = 1'b1;
                            bus_src[BUS_HIOUT] = 1'b1;
                            reg_en[EN_RIN]     = 1'b1;
                        end
                    end
                    OP_MFLO: begin
                        if (state == S_T3) begin
                            gsel[G_RA]         = 1'b1;
                            bus_src[BUS_LOOUT] = 1'b1;
                            reg_en[EN_RIN]     = 1'b1;
                        end
                    end
                    // nop, halt and undefined opcodes: T3 with all controls low.
                    default: ;
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized scoreboard bench for control_unit.
// Stimulus builds each instruction's expected micro-step sequence from a
// table of named control signals and queues one expected vector per cycle;
// a negedge monitor pops and compares against the DUT outputs.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr, con_ff, stop;
    logic [31:0] ir;
    logic        run, read, write, con_in, inc_pc;
    logic [8:0]  bus_src;
    logic [9:0]  reg_en;
    logic [2:0]  gsel;
    logic [4:0]  alu_control;

    control_unit dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
        .run(run), .bus_src(bus_src), .reg_en(reg_en), .gsel(gsel),
        .read(read), .write(write), .con_in(con_in), .inc_pc(inc_pc),
        .alu_control(alu_control)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       run;
        logic [8:0] bus;
        logic [9:0] en;
        logic [2:0] g;
        logic       rd, wr, ci, ip;
        logic [4:0] alu;
    } vec_t;

    typedef struct {
        vec_t       v;
        logic [4:0] op;
        int         step;
    } exp_t;

    // Bus drivers
    localparam logic [8:0] NB = 9'h000, POUT = 9'h001, MDROUT = 9'h002, COUT = 9'h004,
                           BAOUT = 9'h008, ROUT = 9'h010, HIOUT = 9'h020, LOOUT = 9'h040,
                           ZLOOUT = 9'h080, ZHIOUT = 9'h100;
    // Register enables
    localparam logic [9:0] NE = 10'h000, PEN = 10'h001, MAREN = 10'h002, MDREN = 10'h004,
                           IREN = 10'h008, YEN = 10'h010, ZLOEN = 10'h020, ZHIEN = 10'h040,
                           HIEN = 10'h080, LOEN = 10'h100, RIN = 10'h200;
    localparam logic [2:0] NG = 3'b000, GRA = 3'b001, GRB = 3'b010, GRC = 3'b100;
    localparam logic [4:0] A_ADD = 5'b00011;
    localparam vec_t       IDLE = '0;

    localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, ADD = 5'b00011,
                           SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110, ADDI = 5'b01100,
                           MUL = 5'b01111, BR = 5'b10010, JR = 5'b10100, MFHI = 5'b11000,
                           MFLO = 5'b11001, NOP = 5'b11010, HLT = 5'b11011;

    exp_t sb[$];
    vec_t prog[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic [8:0] b, input logic [9:0] e, input logic [2:0] g,
                                input logic [4:0] a = 5'd0, input logic rd = 1'b0,
                                input logic wr = 1'b0, input logic ci = 1'b0,
                                input logic ip = 1'b0);
        vec_t v;
        v.run = 1'b1; v.bus = b; v.en = e; v.g = g;
        v.rd = rd; v.wr = wr; v.ci = ci; v.ip = ip; v.alu = a;
        return v;
    endfunction

    // Reference microprogram: fetch followed by the instruction's own steps.
    function automatic void build(input logic [4:0] op, input logic con);
        prog.delete();
        prog.push_back(mk(POUT, MAREN, NG, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        prog.push_back(mk(NB, MDREN, NG, 5'd0, 1'b1));
        prog.push_back(mk(MDROUT, IREN, NG));
        case (op)
            LD, LDI, ST: begin
                prog.push_back(mk(BAOUT, YEN, GRB));
                prog.push_back(mk(COUT, ZLOEN, NG, A_ADD));
                if (op == LDI) begin
                    prog.push_back(mk(ZLOOUT, RIN, GRA));
                end else begin
                    prog.push_back(mk(ZLOOUT, MAREN, NG));
                    if (op == LD) begin
                        prog.push_back(mk(NB, MDREN, NG, 5'd0, 1'b1));
                        prog.push_back(mk(MDROUT, RIN, GRA));
                    end else begin
                        prog.push_back(mk(ROUT, MDREN, GRA));
                        prog.push_back(mk(NB, NE, NG, 5'd0, 1'b0, 1'b1));
                    end
                end
            end
            ADD, SUB, AND_, OR_: begin
                prog.push_back(mk(ROUT, YEN, GRB));
                prog.push_back(mk(ROUT, ZLOEN, GRC, op));
                prog.push_back(mk(ZLOOUT, RIN, GRA));
            end
            ADDI: begin
                prog.push_back(mk(ROUT, YEN, GRB));
                prog.push_back(mk(COUT, ZLOEN, NG, A_ADD));
                prog.push_back(mk(ZLOOUT, RIN, GRA));
            end
            MUL: begin
                prog.push_back(mk(ROUT, YEN, GRA));
                prog.push_back(mk(ROUT, ZLOEN | ZHIEN, GRB, MUL));
                prog.push_back(mk(ZLOOUT, LOEN, NG));
                prog.push_back(mk(ZHIOUT, HIEN, NG));
            end
            BR: begin
                prog.push_back(mk(ROUT, NE, GRA, 5'd0, 1'b0, 1'b0, 1'b1));
                prog.push_back(mk(POUT, YEN, NG));
                prog.push_back(mk(COUT, ZLOEN, NG, A_ADD));
                prog.push_back(con ? mk(ZLOOUT, PEN, NG) : mk(NB, NE, NG));
            end
            JR:      prog.push_back(mk(ROUT, PEN, GRA));
            MFHI:    prog.push_back(mk(HIOUT, RIN, GRA));
            MFLO:    prog.push_back(mk(LOOUT, RIN, GRA));
            default: prog.push_back(mk(NB, NE, NG));
        endcase
    endfunction

    // One clock: drive inputs just after the edge and queue the expected outputs.
    task automatic step(input logic c, input logic [31:0] i, input logic cf, input logic sp,
                        input vec_t e, input logic [4:0] op, input int st);
        exp_t x;
        @(posedge clk);
        #1;
        clr = c; ir = i; con_ff = cf; stop = sp;
        x.v = e; x.op = op; x.step = st;
        sb.push_back(x);
    endtask

    // Run one instruction from T0; optionally raise clr at step abort_at.
    task automatic run_instr(input logic [4:0] op, input logic con, input logic stp,
                             input int abort_at, output logic halted);
        int n;
        build(op, con);
        n = prog.size();
        halted = 1'b0;
        for (int k = 0; k < n; k++) begin
            logic [31:0] iv;
            logic        cv, sv, cl;
            iv = (k < 3) ? {op, 27'($urandom)} : $urandom;
            cv = (k >= 3) ? con : 1'($urandom);
            sv = (k == n - 1) ? stp : 1'($urandom);
            cl = (k == abort_at);
            step(cl, iv, cv, sv, prog[k], op, k);
            if (cl) begin
                step(1'b0, $urandom, 1'($urandom), 1'($urandom), IDLE, op, 90);
                return;
            end
        end
        halted = stp || (op == HLT);
    endtask

    // Sit in HALT with random inputs, then clear back through RESET.
    task automatic idle_halt(input int n);
        for (int k = 0; k < n; k++)
            step(k == n - 1, $urandom, 1'($urandom), 1'($urandom), IDLE, HLT, 100 + k);
        step(1'b0, $urandom, 1'($urandom), 1'($urandom), IDLE, HLT, 99);
    endtask

    // Monitor: compare every cycle that has a queued expectation.
    always @(negedge clk) begin
        exp_t e;
        vec_t a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {run, bus_src, reg_en, gsel, read, write, con_in, inc_pc, alu_control};
            n_vec++;
            if (a !== e.v) begin
                n_miss++;
                $display("FAIL outputs op=%b step=%0d got=%h want=%h", e.op, e.step, a, e.v);
            end
            n_vec++;
            if ($countones(bus_src) > 1) begin
                n_miss++;
                $display("FAIL bus_onehot op=%b step=%0d got=%h want=at most one bit",
                         e.op, e.step, bus_src);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       h;
        logic [4:0] op;
        int         ab;
        logic [4:0] dir_ops[$];

        clr = 1'b1; ir = 32'h0; con_ff = 1'b0; stop = 1'b0;
        step(1'b1, 32'h0, 1'b0, 1'b0, IDLE, 5'd0, 80);
        step(1'b0, 32'h0, 1'b0, 1'b0, IDLE, 5'd0, 81);

        // Directed instructions, each followed directly by the next fetch.
        run_instr(MFHI, 1'b0, 1'b0, -1, h);
        run_instr(SUB,  1'b0, 1'b0, -1, h);
        run_instr(BR,   1'b0, 1'b0, -1, h);
        run_instr(BR,   1'b1, 1'b0, -1, h);
        dir_ops = '{LD, LDI, ADDI, MUL, JR, MFLO, NOP, ADD, AND_, OR_, 5'b00111, 5'b11111};
        foreach (dir_ops[i]) run_instr(dir_ops[i], 1'($urandom), 1'b0, -1, h);

        // st with stop at T7 -> HALT, ir changes ignored until clr.
        run_instr(ST, 1'b0, 1'b1, -1, h);
        if (h) idle_halt(6);
        // clr during ld T5.
        run_instr(LD, 1'b0, 1'b0, 5, h);
        // clr wins over stop on a final step.
        run_instr(LDI, 1'b0, 1'b1, 5, h);
        // halt opcode enters HALT even without stop.
        run_instr(HLT, 1'b0, 1'b0, -1, h);
        if (h) idle_halt(3);

        for (int n = 0; n < 300; n++) begin
            op = 5'($urandom);
            ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_instr(op, 1'($urandom), ($urandom_range(0, 7) == 0), ab, h);
            if (h) idle_halt(int'($urandom_range(1, 4)));
        end

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain got=%0d want=0 pending", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
